// File: rtl/tdm_demux_1to2_if.sv
// Tagged-beat input and demultiplexed channel outputs of tdm_demux_1to2.
// master = stream source / channel consumer, slave = the demultiplexer.
interface tdm_demux_1to2_if #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     din;
    logic                 din_valid;
    logic                 s0;
    logic                 err_clr;
    logic [WIDTH-1:0]     y0;
    logic [WIDTH-1:0]     y1;
    logic                 y0_valid;
    logic                 y1_valid;
    logic                 pair_valid;
    logic                 locked;
    logic                 seq_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output din, din_valid, s0, err_clr,
        input  y0, y1, y0_valid, y1_valid, pair_valid, locked, seq_err, err_cnt
    );

    modport slave (
        input  din, din_valid, s0, err_clr,
        output y0, y1, y0_valid, y1_valid, pair_valid, locked, seq_err, err_cnt
    );
endinterface

// File: rtl/tdm_demux_1to2.sv
// Two-channel TDM demultiplexer: routes tagged beats to registered channel
// outputs, tracks ch0->ch1 pair alignment and counts sequence errors.
module tdm_demux_1to2 #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    tdm_demux_1to2_if.slave  bus
);
    typedef enum logic [1:0] {HUNT, GOT0, GOT1} state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_y0;
    logic [WIDTH-1:0]     r_y1;
    logic                 r_y0_valid;
    logic                 r_y1_valid;
    logic                 r_pair_valid;
    logic                 r_locked;
    logic                 r_seq_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_seq_err;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // A repeated tag breaks alternation; it only counts once lock was achieved.
    always_comb begin
        w_seq_err = bus.din_valid && r_locked &&
                    (((r_state == GOT0) && !bus.s0) || ((r_state == GOT1) && bus.s0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= HUNT;
            r_y0         <= '0;
            r_y1         <= '0;
            r_y0_valid   <= 1'b0;
            r_y1_valid   <= 1'b0;
            r_pair_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_seq_err    <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_y0_valid   <= 1'b0;
            r_y1_valid   <= 1'b0;
            r_pair_valid <= 1'b0;
            r_seq_err    <= w_seq_err;
            if (bus.din_valid) begin
                if (bus.s0) begin
                    r_y1       <= bus.din;
                    r_y1_valid <= 1'b1;
                end else begin
                    r_y0       <= bus.din;
                    r_y0_valid <= 1'b1;
                end
                case (r_state)
                    HUNT: if (!bus.s0) r_state <= GOT0;
                    GOT0: begin
                        if (bus.s0) begin
                            r_pair_valid <= 1'b1;
                            r_locked     <= 1'b1;
                            r_state      <= GOT1;
                        end else if (w_seq_err) begin
                            r_locked <= 1'b0;
                        end
                    end
                    GOT1: begin
                        if (bus.s0) begin
                            r_state <= HUNT;
                            if (w_seq_err) r_locked <= 1'b0;
                        end else begin
                            r_state <= GOT0;
                        end
                    end
                    default: r_state <= HUNT;
                endcase
            end
            // Clear wins over the old count but a coincident error still counts.
            if (bus.err_clr)
                r_err_cnt <= ERR_CNT_W'(w_seq_err);
            else if (w_seq_err)
                r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign bus.y0         = r_y0;
    assign bus.y1         = r_y1;
    assign bus.y0_valid   = r_y0_valid;
    assign bus.y1_valid   = r_y1_valid;
    assign bus.pair_valid = r_pair_valid;
    assign bus.locked     = r_locked;
    assign bus.seq_err    = r_seq_err;
    assign bus.err_cnt    = r_err_cnt;
endmodule

// File: tb/tb_tdm_demux_1to2.sv
// Bench for tdm_demux_1to2: directed vector table plus randomized beats
// compared against a tag-history reference model; 8-bit and 2-bit counters.
module tb_tdm_demux_1to2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tdm_demux_1to2_if #(.WIDTH(8), .ERR_CNT_W(8)) if8 ();
    tdm_demux_1to2_if #(.WIDTH(8), .ERR_CNT_W(2)) if2 ();

    tdm_demux_1to2 #(.WIDTH(8), .ERR_CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    tdm_demux_1to2 #(.WIDTH(8), .ERR_CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        logic       r, v, s, c;
        logic [7:0] d;
        logic [7:0] ey0, ey1;
        logic       ey0v, ey1v, epv, elk, eerr;
        logic [7:0] ec8;
        logic [1:0] ec2;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // reference model state
    int         m_last;
    logic       m_locked;
    logic [7:0] m_y0, m_y1;
    logic       m_y0v, m_y1v, m_pv, m_err;
    int         m_c8, m_c2;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic add(input logic r, v, s, input logic [7:0] d, input logic c,
                       input logic [7:0] y0, y1, input logic y0v, y1v, pv, lk, er,
                       input logic [7:0] c8, input logic [1:0] c2);
        vec_t e;
        e.r = r; e.v = v; e.s = s; e.d = d; e.c = c;
        e.ey0 = y0; e.ey1 = y1; e.ey0v = y0v; e.ey1v = y1v; e.epv = pv;
        e.elk = lk; e.eerr = er; e.ec8 = c8; e.ec2 = c2;
        tbl.push_back(e);
    endtask

    task automatic drive(input logic r, v, s, input logic [7:0] d, input logic c);
        rst = r;
        if8.din_valid = v; if8.s0 = s; if8.din = d; if8.err_clr = c;
        if2.din_valid = v; if2.s0 = s; if2.din = d; if2.err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic cmp_all(input string tag, input logic [7:0] y0, y1,
                           input logic y0v, y1v, pv, lk, er, input int c8, c2);
        chk({tag, " y0"}, int'(if8.y0), int'(y0));
        chk({tag, " y1"}, int'(if8.y1), int'(y1));
        chk({tag, " y0_valid"}, int'(if8.y0_valid), int'(y0v));
        chk({tag, " y1_valid"}, int'(if8.y1_valid), int'(y1v));
        chk({tag, " pair_valid"}, int'(if8.pair_valid), int'(pv));
        chk({tag, " locked"}, int'(if8.locked), int'(lk));
        chk({tag, " seq_err"}, int'(if8.seq_err), int'(er));
        chk({tag, " err_cnt8"}, int'(if8.err_cnt), c8);
        chk({tag, " err_cnt2"}, int'(if2.err_cnt), c2);
        chk({tag, " w2 pair_valid"}, int'(if2.pair_valid), int'(pv));
    endtask

    // Behavioural model: a pair is a ch1 beat right after a ch0 beat; once
    // locked, any beat repeating the previous tag is an alternation error.
    task automatic model(input logic r, v, s, input logic [7:0] d, input logic c);
        if (r) begin
            m_last = -1; m_locked = 0; m_y0 = 0; m_y1 = 0;
            m_y0v = 0; m_y1v = 0; m_pv = 0; m_err = 0; m_c8 = 0; m_c2 = 0;
            return;
        end
        m_y0v = 0; m_y1v = 0; m_pv = 0; m_err = 0;
        if (v) begin
            if (s) begin m_y1 = d; m_y1v = 1; end
            else   begin m_y0 = d; m_y0v = 1; end
            if (s && m_last == 0) begin
                m_pv = 1; m_locked = 1;
            end else if (m_locked && int'(s) == m_last) begin
                m_err = 1; m_locked = 0;
            end
            m_last = int'(s);
        end
        if (c) begin
            m_c8 = int'(m_err); m_c2 = int'(m_err);
        end else if (m_err) begin
            m_c8 = (m_c8 < 255) ? m_c8 + 1 : 255;
            m_c2 = (m_c2 < 3) ? m_c2 + 1 : 3;
        end
    endtask

    initial begin
        logic [7:0] py1;
        // reset and basic pair
        add(1,0,0,8'h00,0, 8'h00,8'h00, 0,0,0,0,0, 0,0);
        add(0,1,0,8'h11,0, 8'h11,8'h00, 1,0,0,0,0, 0,0);
        add(0,1,1,8'h22,0, 8'h11,8'h22, 0,1,1,1,0, 0,0);
        // repeated ch0 while locked, then recovery
        add(0,1,0,8'hA0,0, 8'hA0,8'h22, 1,0,0,1,0, 0,0);
        add(0,1,0,8'hA1,0, 8'hA1,8'h22, 1,0,0,0,1, 1,1);
        add(0,1,1,8'hB0,0, 8'hA1,8'hB0, 0,1,1,1,0, 1,1);
        // repeated ch1 while locked drops to hunt; next ch1 is silent
        add(0,1,1,8'h33,0, 8'hA1,8'h33, 0,1,0,0,1, 2,2);
        add(0,1,1,8'h44,0, 8'hA1,8'h44, 0,1,0,0,0, 2,2);
        // pair across idle gap (idle beats carry junk data/tag)
        add(0,1,0,8'h55,0, 8'h55,8'h44, 1,0,0,0,0, 2,2);
        add(0,0,1,8'hEE,0, 8'h55,8'h44, 0,0,0,0,0, 2,2);
        add(0,0,0,8'hEE,0, 8'h55,8'h44, 0,0,0,0,0, 2,2);
        add(0,0,1,8'hEE,0, 8'h55,8'h44, 0,0,0,0,0, 2,2);
        add(0,1,1,8'h66,0, 8'h55,8'h66, 0,1,1,1,0, 2,2);
        add(0,0,0,8'h00,1, 8'h55,8'h66, 0,0,0,1,0, 0,0);
        // five errors: 2-bit counter saturates at 3
        py1 = 8'h66;
        for (int k = 1; k <= 5; k++) begin
            add(0,1,0,8'hC0+8'(k),0, 8'hC0+8'(k),py1, 1,0,0,1,0, 8'(k-1),2'((k-1 > 3) ? 3 : k-1));
            add(0,1,0,8'hD0+8'(k),0, 8'hD0+8'(k),py1, 1,0,0,0,1, 8'(k),2'((k > 3) ? 3 : k));
            add(0,1,1,8'hE0+8'(k),0, 8'hD0+8'(k),8'hE0+8'(k), 0,1,1,1,0, 8'(k),2'((k > 3) ? 3 : k));
            py1 = 8'hE0 + 8'(k);
        end
        // clear coincident with an error leaves count at 1
        add(0,1,0,8'hF0,0, 8'hF0,8'hE5, 1,0,0,1,0, 5,3);
        add(0,1,0,8'hF1,1, 8'hF1,8'hE5, 1,0,0,0,1, 1,1);
        add(0,1,1,8'hF2,0, 8'hF1,8'hF2, 0,1,1,1,0, 1,1);
        // reset mid-pair discards the coincident beat and the held ch0
        add(0,1,0,8'h77,0, 8'h77,8'hF2, 1,0,0,1,0, 1,1);
        add(1,1,1,8'h88,0, 8'h00,8'h00, 0,0,0,0,0, 0,0);
        add(0,1,1,8'h99,0, 8'h00,8'h99, 0,1,0,0,0, 0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].c);
            cmp_all($sformatf("vec%0d", i), tbl[i].ey0, tbl[i].ey1, tbl[i].ey0v,
                    tbl[i].ey1v, tbl[i].epv, tbl[i].elk, tbl[i].eerr,
                    int'(tbl[i].ec8), int'(tbl[i].ec2));
        end

        // randomized traffic against the reference model
        model(1, 0, 0, 8'h00, 0);
        drive(1, 0, 0, 8'h00, 0);
        for (int n = 0; n < 3000; n++) begin
            logic       r, v, s, c;
            logic [7:0] d;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 63) == 0);
            d = 8'($urandom);
            drive(r, v, s, d, c);
            model(r, v, s, d, c);
            cmp_all($sformatf("rnd%0d", n), m_y0, m_y1, m_y0v, m_y1v, m_pv,
                    m_locked, m_err, m_c8, m_c2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
